// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU datapath: word/address widths and the
// memory-access sequencer state encoding.
package cpu4_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        READ  = 3'd4,
        RESP  = 3'd5
    } mem_state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Memory-access sequencer between the control unit and the RAM. Address and
// write data are captured at acceptance (MAR/MDR) so every RAM pin is a flop.
module ram_access_ctrl #(
    parameter int DATA_W       = cpu4_pkg::DATA_W,
    parameter int ADDR_W       = cpu4_pkg::ADDR_W,
    parameter int WRITE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_cs,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    import cpu4_pkg::*;

    if (WRITE_CYCLES < 1 || WRITE_CYCLES > 7) begin : gBadWriteCycles
        $fatal(1, "ram_access_ctrl: WRITE_CYCLES must lie in 1..7");
    end

    localparam logic [2:0] WR_LAST = 3'(WRITE_CYCLES - 1);

    mem_state_t        stateReg;
    logic [ADDR_W-1:0] marReg;
    logic [DATA_W-1:0] mdrReg;
    logic [DATA_W-1:0] rdataReg;
    logic              weReg;
    logic [2:0]        wrCntReg;
    logic              readyReg;
    logic              csReg;
    logic              wenReg;
    logic              rspValidReg;

    // Outputs are set on the edge that enters the state they belong to, so each
    // one is a plain flop. readyReg mirrors "in IDLE" but stays low under reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            marReg      <= '0;
            mdrReg      <= '0;
            rdataReg    <= '0;
            weReg       <= 1'b0;
            wrCntReg    <= '0;
            readyReg    <= 1'b0;
            csReg       <= 1'b0;
            wenReg      <= 1'b0;
            rspValidReg <= 1'b0;
        end else begin
            rspValidReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    readyReg <= 1'b1;
                    if (readyReg && req_valid) begin
                        marReg   <= req_addr;
                        mdrReg   <= req_wdata;
                        weReg    <= req_we;
                        readyReg <= 1'b0;
                        csReg    <= 1'b1;
                        stateReg <= SETUP;
                    end
                end
                SETUP: begin
                    if (weReg) begin
                        wenReg   <= 1'b1;
                        wrCntReg <= WR_LAST;
                        stateReg <= WRITE;
                    end else begin
                        stateReg <= READ;
                    end
                end
                WRITE: begin
                    if (wrCntReg == 3'd0) begin
                        wenReg   <= 1'b0;
                        stateReg <= HOLD;
                    end else begin
                        wrCntReg <= wrCntReg - 3'd1;
                    end
                end
                HOLD: begin
                    // Writes answer with the stored word so rsp_rdata is always meaningful.
                    rdataReg    <= mdrReg;
                    csReg       <= 1'b0;
                    rspValidReg <= 1'b1;
                    stateReg    <= RESP;
                end
                READ: begin
                    rdataReg    <= ram_dout;
                    csReg       <= 1'b0;
                    rspValidReg <= 1'b1;
                    stateReg    <= RESP;
                end
                RESP: begin
                    readyReg <= 1'b1;
                    stateReg <= IDLE;
                end
                default: begin
                    readyReg <= 1'b0;
                    csReg    <= 1'b0;
                    wenReg   <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = readyReg;
    assign rsp_valid    = rspValidReg;
    assign rsp_rdata    = rdataReg;
    assign ram_cs       = csReg;
    assign ram_write_en = wenReg;
    assign ram_addr     = marReg;
    assign ram_din      = mdrReg;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: one instance with single-cycle strobes,
// one with three-cycle strobes, each driving its own behavioural RAM.
module tb_ram_access_ctrl;

    logic       clk;
    logic       rst;
    logic       reqValid;
    logic       reqWe;
    logic [3:0] reqAddr;
    logic [3:0] reqWdata;
    logic       useB;

    logic       validA, readyA, rspA, csA, wenA;
    logic [3:0] rdataA, addrA, dinA, doutA;
    logic       validB, readyB, rspB, csB, wenB;
    logic [3:0] rdataB, addrB, dinB, doutB;

    logic [3:0] memA [16];
    logic [3:0] memB [16];

    int checkCount = 0;
    int passCount  = 0;
    int pulseCntA  = 0;

    assign validA = reqValid & ~useB;
    assign validB = reqValid & useB;

    ram_access_ctrl #(.DATA_W(4), .ADDR_W(4), .WRITE_CYCLES(1)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(validA), .req_ready(readyA), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspA), .rsp_rdata(rdataA),
        .ram_cs(csA), .ram_write_en(wenA), .ram_addr(addrA),
        .ram_din(dinA), .ram_dout(doutA)
    );

    ram_access_ctrl #(.DATA_W(4), .ADDR_W(4), .WRITE_CYCLES(3)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(validB), .req_ready(readyB), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspB), .rsp_rdata(rdataB),
        .ram_cs(csB), .ram_write_en(wenB), .ram_addr(addrB),
        .ram_din(dinB), .ram_dout(doutB)
    );

    // Asynchronous-read RAMs, written on the rising edge under cs & write_en.
    always @(posedge clk) if (csA && wenA) memA[addrA] <= dinA;
    always @(posedge clk) if (csB && wenB) memB[addrB] <= dinB;
    assign doutA = memA[addrA];
    assign doutB = memB[addrB];

    always @(negedge clk) if (rspA === 1'b1) pulseCntA <= pulseCntA + 1;

    logic       curReady, curRsp, curCs, curWen;
    logic [3:0] curRdata, curAddr, curDin;
    assign curReady = useB ? readyB : readyA;
    assign curRsp   = useB ? rspB   : rspA;
    assign curCs    = useB ? csB    : csA;
    assign curWen   = useB ? wenB   : wenA;
    assign curRdata = useB ? rdataB : rdataA;
    assign curAddr  = useB ? addrB  : addrA;
    assign curDin   = useB ? dinB   : dinA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Waits for ready, presents one request for the acceptance edge, then drops valid.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [3:0] data,
                         input string tag);
        int n;
        n = 0;
        while (curReady !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        if (n >= 30) check($sformatf("%s_ready_timeout", tag), 32'(curReady), 32'd1);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = data;
        tick;
        reqValid = 1'b0;
    endtask

    // Called in cycle 1 (the cycle after acceptance); follows the transfer to its response.
    task automatic waitRsp(input int expLat, input logic [3:0] expData, input int expWen,
                           input logic [3:0] expAddr, input logic [3:0] expDin,
                           input logic chkDin, input string tag);
        int   cyc;
        int   wenCnt;
        int   wenRise;
        logic prevWen;
        logic stable;
        logic got;
        cyc = 1; wenCnt = 0; wenRise = 0; prevWen = 1'b0; stable = 1'b1; got = 1'b0;
        while (!got && cyc <= 20) begin
            if (curWen === 1'b1) wenCnt++;
            if (curWen === 1'b1 && prevWen !== 1'b1) wenRise++;
            prevWen = curWen;
            if (curCs === 1'b1 && (curAddr !== expAddr || (chkDin && curDin !== expDin)))
                stable = 1'b0;
            if (curRsp === 1'b1) got = 1'b1;
            else begin
                tick;
                cyc++;
            end
        end
        check($sformatf("%s_latency", tag), got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(expLat));
        check($sformatf("%s_rdata", tag), 32'(curRdata), 32'(expData));
        check($sformatf("%s_wen_cycles", tag), 32'(wenCnt), 32'(expWen));
        check($sformatf("%s_wen_runs", tag), 32'(wenRise), (expWen > 0) ? 32'd1 : 32'd0);
        check($sformatf("%s_addr_data_stable", tag), 32'(stable), 32'd1);
        check($sformatf("%s_cs_in_resp", tag), 32'(curCs), 32'd0);
    endtask

    initial begin
        int   seen;
        int   pulseStart;
        logic [3:0] av;

        useB = 1'b0; rst = 1'b1; reqValid = 1'b1; reqWe = 1'b1; reqAddr = 4'd4; reqWdata = 4'd6;

        // Reset held three cycles with a request pending: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("rst%0d_ready", i), 32'(readyA), 32'd0);
            check($sformatf("rst%0d_cs", i), 32'(csA), 32'd0);
            check($sformatf("rst%0d_wen", i), 32'(wenA), 32'd0);
            check($sformatf("rst%0d_rsp", i), 32'(rspA), 32'd0);
        end
        check("rst_readyB", 32'(readyB), 32'd0);
        rst = 1'b0; reqValid = 1'b0;
        tick;
        check("release_ready", 32'(readyA), 32'd1);
        check("release_cs", 32'(csA), 32'd0);

        // Single-cycle strobe: write 7=C, write 1=9, read 1.
        issue(1'b1, 4'd7, 4'hC, "wr7");
        waitRsp(4, 4'hC, 1, 4'd7, 4'hC, 1'b1, "wr7");
        issue(1'b1, 4'd1, 4'h9, "wr1");
        waitRsp(4, 4'h9, 1, 4'd1, 4'h9, 1'b1, "wr1");
        issue(1'b0, 4'd1, 4'h0, "rd1");
        waitRsp(3, 4'h9, 0, 4'd1, 4'h0, 1'b0, "rd1");
        tick;
        check("rd1_pulse_drop", 32'(rspA), 32'd0);
        check("rd1_rdata_hold", 32'(rdataA), 32'h9);

        // Fields change while busy: the write must use the values seen at acceptance.
        issue(1'b1, 4'd2, 4'h5, "busy");
        reqValid = 1'b1; reqWe = 1'b0; reqAddr = 4'd7; reqWdata = 4'h3;
        check("busy_ready", 32'(readyA), 32'd0);
        waitRsp(4, 4'h5, 1, 4'd2, 4'h5, 1'b1, "busy");
        check("resp_ready", 32'(readyA), 32'd0);
        tick;
        check("idle_ready", 32'(readyA), 32'd1);
        check("idle_cs", 32'(csA), 32'd0);
        tick;
        reqValid = 1'b0;
        check("second_accept_cs", 32'(csA), 32'd1);
        check("second_accept_addr", 32'(addrA), 32'd7);
        waitRsp(3, 4'hC, 0, 4'd7, 4'h0, 1'b0, "rd7");
        issue(1'b0, 4'd2, 4'h0, "rd2");
        waitRsp(3, 4'h5, 0, 4'd2, 4'h0, 1'b0, "rd2");

        // Three-cycle strobe instance.
        useB = 1'b1;
        issue(1'b1, 4'd15, 4'hA, "wr15");
        waitRsp(6, 4'hA, 3, 4'd15, 4'hA, 1'b1, "wr15");

        // Reset lands in the middle of a write.
        issue(1'b1, 4'd3, 4'h6, "cut");
        tick;
        check("cut_wen_on", 32'(wenB), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("cut_wen", 32'(wenB), 32'd0);
        check("cut_cs", 32'(csB), 32'd0);
        check("cut_rsp", 32'(rspB), 32'd0);
        check("cut_ready", 32'(readyB), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rspB === 1'b1) seen++;
        end
        check("cut_no_response", 32'(seen), 32'd0);
        issue(1'b0, 4'd15, 4'h0, "rd15");
        waitRsp(3, 4'hA, 0, 4'd15, 4'h0, 1'b0, "rd15");

        // Sweep all addresses on the single-cycle instance.
        useB = 1'b0;
        pulseStart = pulseCntA;
        for (int a = 0; a < 16; a++) begin
            av = 4'(a);
            issue(1'b1, av, ~av, $sformatf("sww%0d", a));
            waitRsp(4, ~av, 1, av, ~av, 1'b1, $sformatf("sww%0d", a));
        end
        for (int a = 0; a < 16; a++) begin
            av = 4'(a);
            issue(1'b0, av, 4'h0, $sformatf("swr%0d", a));
            waitRsp(3, ~av, 0, av, 4'h0, 1'b0, $sformatf("swr%0d", a));
        end
        tick;
        tick;
        check("sweep_pulses", 32'(pulseCntA - pulseStart), 32'd32);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
